regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Write-back scheduler for the single-write-port Y86-64 register file (16 x 64-bit, ids 0..15).
- Each cycle accepts up to two write requests: E (valE -> dstE) and M (valM -> dstM).
- Buffers them in program order in a small circular queue and drains one write per cycle onto the register file write port.
- Provides pending-write forwarding for two read ids, so decode sees values not yet committed.

Parameters:
DATA_W, 64, write value width
REG_ID_W, 4, register id width
DEPTH, 4, queue entries; power of 2, >= 2
RNONE, 4'hF, "no register" id; never enqueued, never forwarded

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
e_valid  in  1  E write request
e_dst  in  REG_ID_W  E destination id
e_val  in  DATA_W  E value
m_valid  in  1  M write request
m_dst  in  REG_ID_W  M destination id
m_val  in  DATA_W  M value
wb_ready  out  1  >= 2 free entries; requests are accepted only when high
rf_stall  in  1  register file unavailable; hold the queue head
rf_write_en  out  1  write strobe to register file
rf_write_id  out  REG_ID_W  write id
rf_write_val  out  DATA_W  write value
rd_id_a  in  REG_ID_W  forward lookup id A
rd_id_b  in  REG_ID_W  forward lookup id B
fwd_hit_a  out  1  pending write exists for rd_id_a
fwd_val_a  out  DATA_W  youngest pending value for rd_id_a
fwd_hit_b  out  1  same, port B
fwd_val_b  out  DATA_W  same, port B
pending_cnt  out  $clog2(DEPTH)+1  occupied entries
busy  out  1  state != IDLE
overflow_err  out  1  sticky: a request arrived while wb_ready was low

Behaviour:
- Single clock domain: clk. Reset: rst, asynchronous, active-high.
- Reset state:
  - head/tail pointers and count = 0; state = IDLE.
  - overflow_err = 0; wb_ready = 1.
  - rf_write_en = 0, rf_write_id = RNONE, rf_write_val = 0.
  - fwd_* = 0.
  - Entries are invalidated; contents are don't-care.
  - Reset mid-drain discards all pending writes; no partial write is issued.
- Enqueue:
  - A request is effective only if x_valid = 1, x_dst != RNONE and wb_ready = 1.
  - E is written at tail and M at tail+1 (or at tail if E is not effective). M is therefore always younger.
  - When dstE == dstM, M wins in the register file (popq %rsp semantics).
- wb_ready:
  - Registered, computed from post-update count: (DEPTH - count) >= 2.
  - It does not credit a same-cycle drain.
- Overflow: a valid non-RNONE request while wb_ready = 0 is dropped and sets overflow_err. overflow_err clears only on rst.
- Drain:
  - rf_write_* is combinational from the head entry.
  - rf_write_en = (count > 0) & !rf_stall.
  - The head pops on the clock edge at which rf_write_en = 1.
  - Latency: a request accepted at edge N appears on rf_write_* in cycle N..N+1, i.e. the first cycle after the edge, if the queue was empty.
- Simultaneous events:
  - Enqueue of 0/1/2 and pop of 0/1 in the same cycle.
  - count_next = count + enq - pop.
  - Pointers wrap modulo DEPTH.
- FSM, registered:
  - IDLE (count = 0).
  - DRAIN (count > 0, !rf_stall).
  - STALL (count > 0, rf_stall).
  - Transitions are evaluated from count_next and the current rf_stall.
  - In STALL no pop occurs; enqueue proceeds while wb_ready = 1.
- Forwarding (combinational):
  - Search all valid entries, youngest first, for rd_id; the first match drives fwd_val.
  - rd_id == RNONE never hits.
  - The head entry being written this cycle is still searched.
  - Same-cycle incoming requests are not searched.

Optional Feature:
WB_SCHED_FWD_EN
- Defined: forwarding logic is present, as described above.
- Undefined:
  - fwd_hit_a/b are tied 0 and fwd_val_a/b are tied 0. Ports remain.
  - Consumers must stall until busy = 0.

Decomposition:
- Package y86_pkg holds:
  - constants REG_ID_W, DATA_W, RNONE;
  - typedef wb_entry_t {dst, val};
  - enum wb_state_t {IDLE, DRAIN, STALL}.
- One sub-module, wb_fifo:
  - dual-push / single-pop circular buffer;
  - exposes count and its entry array for the forwarding search.

Test Plan:
- Reset, then E(dst=3, val=0x11) alone:
  - next cycle rf_write_en = 1, id = 3, val = 0x11;
  - following cycle busy = 0, pending_cnt = 0.
- E(4, 0xA) and M(4, 0xB) in the same cycle:
  - writes issue id 4 = 0xA, then id 4 = 0xB on consecutive cycles;
  - before the drain, fwd on rd_id_a = 4 returns 0xB.
- rf_stall = 1; issue two double requests (ids 1, 2, 5, 6):
  - count reaches 4, wb_ready = 0, state = STALL;
  - a third request sets overflow_err = 1 and is dropped;
  - release stall: drain order 1, 2, 5, 6.
- e_dst = RNONE, m_dst = 7, with rd_id_b = 15:
  - only id 7 is enqueued and written;
  - fwd_hit_b = 0 throughout.
- Steady state, one single request per cycle for 10 cycles:
  - pointers wrap past DEPTH;
  - writes are in order, with no loss and no duplicates.
- Assert rst while count = 3:
  - immediately rf_write_en = 0, pending_cnt = 0, overflow_err = 0;
  - no stale write after rst is released.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and constants for the Y86-64 register-file write-back scheduler.
package y86_pkg;
  localparam int REG_ID_W = 4;
  localparam int DATA_W   = 64;
  localparam logic [REG_ID_W-1:0] RNONE = 4'hF;

  typedef struct packed {
    logic [REG_ID_W-1:0] dst;
    logic [DATA_W-1:0]   val;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    STALL = 2'd2
  } wb_state_t;
endpackage

// File: rtl/regfile_wb_scheduler_wb_fifo.sv
// Dual-push / single-pop circular buffer; entry a is older than entry b.
// The entry array is exposed so the top can search it for forwarding.
module wb_fifo
  import y86_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_push_cnt,
  input  wb_entry_t        i_ent_a,
  input  wb_entry_t        i_ent_b,
  input  logic             i_pop,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_next,
  output logic [PTR_W-1:0] o_head,
  output wb_entry_t        o_entries [DEPTH]
);
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] w_tail_p1;

  assign w_tail_p1    = r_tail + PTR_W'(1);
  assign o_count_next = r_count + CNT_W'(i_push_cnt) - CNT_W'(i_pop);

  // Pointer arithmetic truncates to PTR_W bits, which gives the modulo-DEPTH wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(i_pop);
      r_tail  <= r_tail + PTR_W'(i_push_cnt);
      r_count <= o_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push_cnt != 2'd0) r_mem[r_tail] <= i_ent_a;
    if (i_push_cnt == 2'd2) r_mem[w_tail_p1] <= i_ent_b;
  end

  assign o_count   = r_count;
  assign o_head    = r_head;
  assign o_entries = r_mem;
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: queues E/M writes in program order, drains one per cycle.
// Define WB_SCHED_FWD_EN to build the pending-write forwarding search.
module regfile_wb_scheduler
  import y86_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                e_valid,
  input  logic [REG_ID_W-1:0] e_dst,
  input  logic [DATA_W-1:0]   e_val,
  input  logic                m_valid,
  input  logic [REG_ID_W-1:0] m_dst,
  input  logic [DATA_W-1:0]   m_val,
  output logic                wb_ready,
  input  logic                rf_stall,
  output logic                rf_write_en,
  output logic [REG_ID_W-1:0] rf_write_id,
  output logic [DATA_W-1:0]   rf_write_val,
  input  logic [REG_ID_W-1:0] rd_id_a,
  input  logic [REG_ID_W-1:0] rd_id_b,
  output logic                fwd_hit_a,
  output logic [DATA_W-1:0]   fwd_val_a,
  output logic                fwd_hit_b,
  output logic [DATA_W-1:0]   fwd_val_b,
  output logic [CNT_W-1:0]    pending_cnt,
  output logic                busy,
  output logic                overflow_err
);
  // Handshake: a request is taken on a clock edge only when x_valid, x_dst != RNONE
  // and the registered wb_ready are all high; wb_ready guarantees room for two.
  logic             r_ready;
  logic             r_overflow;
  wb_state_t        r_state;
  wb_state_t        w_state_next;
  logic             w_e_eff;
  logic             w_m_eff;
  logic [1:0]       w_push_cnt;
  wb_entry_t        w_ent_a;
  wb_entry_t        w_ent_b;
  logic             w_pop;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_next;
  logic [PTR_W-1:0] w_head;
  wb_entry_t        w_entries [DEPTH];

  assign w_e_eff    = e_valid && (e_dst != RNONE) && r_ready;
  assign w_m_eff    = m_valid && (m_dst != RNONE) && r_ready;
  assign w_push_cnt = {1'b0, w_e_eff} + {1'b0, w_m_eff};
  // M slides into the older slot when E is not effective, keeping M youngest.
  assign w_ent_a    = w_e_eff ? '{dst: e_dst, val: e_val} : '{dst: m_dst, val: m_val};
  assign w_ent_b    = '{dst: m_dst, val: m_val};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push_cnt   (w_push_cnt),
    .i_ent_a      (w_ent_a),
    .i_ent_b      (w_ent_b),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_count_next (w_count_next),
    .o_head       (w_head),
    .o_entries    (w_entries)
  );

  assign rf_write_en  = (w_count != '0) && !rf_stall;
  assign w_pop        = rf_write_en;
  assign rf_write_id  = (w_count != '0) ? w_entries[w_head].dst : RNONE;
  assign rf_write_val = (w_count != '0) ? w_entries[w_head].val : '0;
  assign pending_cnt  = w_count;
  assign wb_ready     = r_ready;
  assign overflow_err = r_overflow;

  // wb_ready looks only at the post-update count; a same-cycle drain earns no credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_ready <= (CNT_W'(DEPTH) - w_count_next) >= CNT_W'(2);
      if (!r_ready && ((e_valid && e_dst != RNONE) || (m_valid && m_dst != RNONE)))
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = IDLE;
    if (w_count_next != '0) w_state_next = rf_stall ? STALL : DRAIN;
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

`ifdef WB_SCHED_FWD_EN
  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so the last match, the youngest, wins.
  always_comb begin
    fwd_hit_a = 1'b0;
    fwd_val_a = '0;
    fwd_hit_b = 1'b0;
    fwd_val_b = '0;
    w_idx     = w_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_head + PTR_W'(k);
      if (CNT_W'(k) < w_count) begin
        if (rd_id_a != RNONE && w_entries[w_idx].dst == rd_id_a) begin
          fwd_hit_a = 1'b1;
          fwd_val_a = w_entries[w_idx].val;
        end
        if (rd_id_b != RNONE && w_entries[w_idx].dst == rd_id_b) begin
          fwd_hit_b = 1'b1;
          fwd_val_b = w_entries[w_idx].val;
        end
      end
    end
  end
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{rd_id_a, rd_id_b};
  assign fwd_hit_a   = 1'b0;
  assign fwd_val_a   = '0;
  assign fwd_hit_b   = 1'b0;
  assign fwd_val_b   = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with an expected-write queue and a
// monitor that checks every register-file write strobe.
module tb_regfile_wb_scheduler;
  import y86_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                clk;
  logic                rst;
  logic                e_valid;
  logic [REG_ID_W-1:0] e_dst;
  logic [DATA_W-1:0]   e_val;
  logic                m_valid;
  logic [REG_ID_W-1:0] m_dst;
  logic [DATA_W-1:0]   m_val;
  logic                wb_ready;
  logic                rf_stall;
  logic                rf_write_en;
  logic [REG_ID_W-1:0] rf_write_id;
  logic [DATA_W-1:0]   rf_write_val;
  logic [REG_ID_W-1:0] rd_id_a;
  logic [REG_ID_W-1:0] rd_id_b;
  logic                fwd_hit_a;
  logic [DATA_W-1:0]   fwd_val_a;
  logic                fwd_hit_b;
  logic [DATA_W-1:0]   fwd_val_b;
  logic [CNT_W-1:0]    pending_cnt;
  logic                busy;
  logic                overflow_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [REG_ID_W+DATA_W-1:0] exp_q[$];

  regfile_wb_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .e_valid(e_valid), .e_dst(e_dst), .e_val(e_val),
    .m_valid(m_valid), .m_dst(m_dst), .m_val(m_val),
    .wb_ready(wb_ready), .rf_stall(rf_stall),
    .rf_write_en(rf_write_en), .rf_write_id(rf_write_id), .rf_write_val(rf_write_val),
    .rd_id_a(rd_id_a), .rd_id_b(rd_id_b),
    .fwd_hit_a(fwd_hit_a), .fwd_val_a(fwd_val_a),
    .fwd_hit_b(fwd_hit_b), .fwd_val_b(fwd_val_b),
    .pending_cnt(pending_cnt), .busy(busy), .overflow_err(overflow_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && rf_write_en === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got id=%h val=%h with nothing expected",
                 rf_write_id, rf_write_val);
      end else begin
        logic [67:0] exp_w;
        exp_w = exp_q.pop_front();
        if ({rf_write_id, rf_write_val} !== exp_w) begin
          n_fail++;
          $display("FAIL write_order: got %h expected %h", {rf_write_id, rf_write_val}, exp_w);
        end
      end
    end
  end

  // Driver: present a request for one cycle; the exp flags say which ones the
  // scheduler should accept and therefore eventually write.
  task automatic req(input logic ev, input logic [3:0] ed, input logic [63:0] evl,
                     input logic mv, input logic [3:0] md, input logic [63:0] mvl,
                     input logic exp_e, input logic exp_m);
    e_valid = ev; e_dst = ed; e_val = evl;
    m_valid = mv; m_dst = md; m_val = mvl;
    if (exp_e) exp_q.push_back({ed, evl});
    if (exp_m) exp_q.push_back({md, mvl});
    @(posedge clk); #1;
    e_valid = 1'b0; m_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (pending_cnt != '0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", 68'(pending_cnt), 68'(0));
  endtask

  logic        exp_hit;
  logic [63:0] exp_fwd;

  initial begin
`ifdef WB_SCHED_FWD_EN
    exp_hit = 1'b1; exp_fwd = 64'hB;
`else
    exp_hit = 1'b0; exp_fwd = 64'h0;
`endif
    rst = 1'b1; rf_stall = 1'b0;
    e_valid = 1'b0; e_dst = RNONE; e_val = '0;
    m_valid = 1'b0; m_dst = RNONE; m_val = '0;
    rd_id_a = 4'd0; rd_id_b = 4'd0;
    #12;
    check("rst_wb_ready", 68'(wb_ready), 68'(1));
    check("rst_wr_en", 68'(rf_write_en), 68'(0));
    check("rst_wr_id", 68'(rf_write_id), 68'(RNONE));
    check("rst_wr_val", 68'(rf_write_val), 68'(0));
    check("rst_pending", 68'(pending_cnt), 68'(0));
    check("rst_busy", 68'(busy), 68'(0));
    check("rst_overflow", 68'(overflow_err), 68'(0));
    check("rst_fwd_hit_a", 68'(fwd_hit_a), 68'(0));
    check("rst_fwd_val_b", 68'(fwd_val_b), 68'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Single E write: visible the first cycle after acceptance, gone the next.
    req(1, 4'd3, 64'h11, 0, RNONE, 64'h0, 1, 0);
    check("t1_wr_en", 68'(rf_write_en), 68'(1));
    check("t1_wr_id_val", {rf_write_id, rf_write_val}, {4'd3, 64'h11});
    @(posedge clk); #1;
    check("t1_busy", 68'(busy), 68'(0));
    check("t1_pending", 68'(pending_cnt), 68'(0));

    // Same destination from E and M: M is younger and must win.
    rd_id_a = 4'd4;
    req(1, 4'd4, 64'hA, 1, 4'd4, 64'hB, 1, 1);
    check("t2_pending", 68'(pending_cnt), 68'(2));
    check("t2_fwd_hit_a", 68'(fwd_hit_a), 68'(exp_hit));
    check("t2_fwd_val_a", 68'(fwd_val_a), 68'(exp_fwd));
    wait_idle();

    // Fill under stall, overflow, then release.
    rf_stall = 1'b1;
    req(1, 4'd1, 64'h1001, 1, 4'd2, 64'h1002, 1, 1);
    check("t3_ready_at2", 68'(wb_ready), 68'(1));
    req(1, 4'd5, 64'h1005, 1, 4'd6, 64'h1006, 1, 1);
    check("t3_pending", 68'(pending_cnt), 68'(4));
    check("t3_ready", 68'(wb_ready), 68'(0));
    check("t3_state", 68'(dut.r_state), 68'(STALL));
    check("t3_busy", 68'(busy), 68'(1));
    check("t3_wr_en", 68'(rf_write_en), 68'(0));
    req(1, 4'd8, 64'h1008, 1, 4'd9, 64'h1009, 0, 0);
    check("t3_overflow", 68'(overflow_err), 68'(1));
    check("t3_pending_drop", 68'(pending_cnt), 68'(4));
    rf_stall = 1'b0;
    wait_idle();
    check("t3_overflow_sticky", 68'(overflow_err), 68'(1));

    // RNONE destination is never enqueued and never forwarded.
    rd_id_b = RNONE;
    req(1, RNONE, 64'h99, 1, 4'd7, 64'h77, 0, 1);
    check("t4_pending", 68'(pending_cnt), 68'(1));
    check("t4_fwd_hit_b", 68'(fwd_hit_b), 68'(0));
    wait_idle();
    check("t4_fwd_hit_b_after", 68'(fwd_hit_b), 68'(0));

    // Steady stream wraps the pointers several times.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) req(1, 4'(i + 1), 64'h5000 + 64'(i), 0, RNONE, 64'h0, 1, 0);
      else            req(0, RNONE, 64'h0, 1, 4'(i + 1), 64'h5000 + 64'(i), 0, 1);
      check("t5_ready", 68'(wb_ready), 68'(1));
    end
    wait_idle();
    check("t5_no_loss", 68'(exp_q.size()), 68'(0));

    // Reset with three writes pending discards them all.
    rf_stall = 1'b1;
    req(1, 4'd9, 64'h9009, 1, 4'd10, 64'h900A, 1, 1);
    req(1, 4'd11, 64'h900B, 0, RNONE, 64'h0, 1, 0);
    check("t6_pending", 68'(pending_cnt), 68'(3));
    #2;
    rst = 1'b1;
    #1;
    check("t6_wr_en", 68'(rf_write_en), 68'(0));
    check("t6_pending_rst", 68'(pending_cnt), 68'(0));
    check("t6_overflow_rst", 68'(overflow_err), 68'(0));
    check("t6_ready_rst", 68'(wb_ready), 68'(1));
    exp_q.delete();
    @(posedge clk); #1;
    rf_stall = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t6_no_stale_wr", 68'(rf_write_en), 68'(0));
      check("t6_busy", 68'(busy), 68'(0));
    end

    check("scoreboard_empty", 68'(exp_q.size()), 68'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
